uart_alu_resp_framer: RTL and testbench
=======================================

Name: uart_alu_resp_framer

Overview:
- Response-side packet framer for the UART ALU.
- Accepts a response descriptor (opcode plus payload length) and the payload byte stream from the ALU/echo datapath.
- Emits a framed byte stream to the UART transmitter.
- Packet format is identical to the command packets the host sends: byte0 opcode, byte1 0x00, byte2 total length LSB, byte3 total length MSB, then payload bytes. Total length includes the 4 header bytes.

Parameters:
- MaxPayloadBytes, 252, largest accepted payload; total length never exceeds MaxPayloadBytes+4.
- HdrBytes, 4, header length in bytes; fixed, parameterised for package consistency only.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- desc_valid_i  input  1  response descriptor valid
- desc_ready_o  output  1  framer accepts descriptor
- desc_opcode_i  input  8  opcode copied to byte0
- desc_len_i  input  16  payload byte count (excludes header)
- pay_data_i  input  8  payload byte
- pay_valid_i  input  1  payload byte valid
- pay_ready_o  output  1  payload byte consumed
- tx_data_o  output  8  byte to UART TX
- tx_valid_o  output  1  tx_data_o valid
- tx_ready_i  input  1  UART TX accepts byte
- busy_o  output  1  packet in progress
- len_err_o  output  1  one-cycle pulse: descriptor rejected for length

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: desc_ready_o=0 during reset, 1 in the first IDLE cycle after; pay_ready_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, len_err_o=0. State=IDLE, counters=0.
- Handshakes: a transfer occurs when valid&ready are both high on a rising edge. tx_valid_o, once raised, stays high with tx_data_o stable until tx_ready_i.
- desc_ready_o=1 only in IDLE.
- FSM states: IDLE, HDR_OP, HDR_RSV, HDR_LLSB, HDR_LMSB, PAYLOAD, DONE.
- IDLE:
  - On descriptor accept with desc_len_i>MaxPayloadBytes: pulse len_err_o next cycle and stay IDLE; no bytes are emitted.
  - Otherwise register opcode and len, compute total=len+4 (16-bit), and go to HDR_OP.
- Header states:
  - tx_valid_o=1 with the byte shown; advance on the tx handshake.
  - Byte order: HDR_OP opcode, HDR_RSV 0x00, HDR_LLSB total[7:0], HDR_LMSB total[15:8].
- HDR_LMSB exit: on handshake, go to PAYLOAD if len!=0, else DONE.
- PAYLOAD is a pass-through:
  - tx_data_o=pay_data_i, tx_valid_o=pay_valid_i, pay_ready_o=tx_ready_i.
  - Both are combinational in this state; no added latency.
  - A remaining-byte counter decrements per transfer. On the transfer where remaining==1, go to DONE.
- DONE: one cycle with all outputs idle, then IDLE. Minimum gap between packets is 1 cycle.
- Latency: the first header byte is presented the cycle after descriptor accept. With tx_ready_i tied high, an L-byte payload packet occupies L+4 consecutive tx cycles.
- busy_o=1 in every state except IDLE.
- Payload bytes presented outside PAYLOAD are never consumed (pay_ready_o=0).
- rst_i mid-packet: abort immediately and return to IDLE next cycle. The partial packet is not completed; upstream must also be reset.
- No tx_ready_i backpressure timeout; the framer holds indefinitely.

Decomposition:
- config_pkg additions:
  - Opcode constants OP_ECHO=8'hEC, OP_ADD32=8'hA0, OP_MUL32=8'hB0, OP_DIV32=8'hC0.
  - HDR_BYTES=4.
  - typedef resp_state_e, the FSM enum.
  - typedef resp_desc_t (opcode[7:0], len[15:0]).
- No sub-module. The FSM and counter form a single block. The UART serializer instance lives in the parent top.

Test Plan:
- Echo, 4 bytes: desc {0xEC, len=4}, payload 42 69 42 69, tx_ready_i=1 -> tx stream EC 00 08 00 42 69 42 69 on 8 consecutive cycles; busy_o low 2 cycles after the last byte.
- MUL result, 4 bytes, with tx_ready_i toggling 1-0-1-0 -> same framing EC→B0 with total 0x0008; tx_data_o held stable while tx_ready_i=0; no byte duplicated or dropped.
- Zero-length packet: desc {0xC0, len=0} -> exactly C0 00 04 00; pay_ready_o never asserted.
- Oversize: desc len=253 -> len_err_o single-cycle pulse, no tx_valid_o, desc_ready_o stays 1. Then len=252 -> total bytes 0x0100 (LSB 00, MSB 01) and 256 bytes out.
- Payload stall: pay_valid_i low for 5 cycles mid-payload -> tx_valid_o low for those cycles; the byte count still completes correctly.
- Reset mid-payload after 2 of 4 payload bytes -> next cycle busy_o=0, tx_valid_o=0. A following echo packet is framed correctly from HDR_OP.

Source files
------------

// File: rtl/uart_alu_resp_framer_pkg.sv
// Shared constants and types for the UART ALU response framer.
package uart_alu_resp_framer_pkg;

  localparam int MAX_PAYLOAD_BYTES = 252;
  localparam int HDR_BYTES         = 4;

  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'hA0;
  localparam logic [7:0] OP_MUL32 = 8'hB0;
  localparam logic [7:0] OP_DIV32 = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_OP   = 3'd1,
    ST_HDR_RSV  = 3'd2,
    ST_HDR_LLSB = 3'd3,
    ST_HDR_LMSB = 3'd4,
    ST_PAYLOAD  = 3'd5,
    ST_DONE     = 3'd6
  } resp_state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] len;
  } resp_desc_t;

endpackage

// File: rtl/uart_alu_resp_framer_if.sv
// Descriptor, payload and TX byte handshakes of the response framer.
// The slave modport is the framer itself; master is its surroundings.
interface uart_alu_resp_framer_if;

  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [7:0]  desc_opcode_i;
  logic [15:0] desc_len_i;
  logic [7:0]  pay_data_i;
  logic        pay_valid_i;
  logic        pay_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        len_err_o;

  modport slave (
    input  desc_valid_i, desc_opcode_i, desc_len_i,
    input  pay_data_i, pay_valid_i, tx_ready_i,
    output desc_ready_o, pay_ready_o, tx_data_o, tx_valid_o,
    output busy_o, len_err_o
  );

  modport master (
    output desc_valid_i, desc_opcode_i, desc_len_i,
    output pay_data_i, pay_valid_i, tx_ready_i,
    input  desc_ready_o, pay_ready_o, tx_data_o, tx_valid_o,
    input  busy_o, len_err_o
  );

endinterface

// File: rtl/uart_alu_resp_framer.sv
// Response packet framer: emits opcode, 0x00, total length LSB/MSB,
// then passes the payload stream straight through to the UART TX.
module uart_alu_resp_framer
  import uart_alu_resp_framer_pkg::*;
#(
  parameter int MaxPayloadBytes = MAX_PAYLOAD_BYTES,
  parameter int HdrBytes        = HDR_BYTES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  uart_alu_resp_framer_if.slave bus
);

  localparam logic [15:0] MAX_LEN  = 16'(MaxPayloadBytes);
  localparam logic [15:0] HDR_LEN  = 16'(HdrBytes);

  resp_state_e state_q;
  resp_state_e state_d;
  resp_desc_t  desc_q;
  logic [15:0] total_q;
  logic [15:0] remaining_q;
  logic        len_err_q;

  logic        desc_ready;
  logic        desc_fire;
  logic        len_too_big;
  logic        pay_fire;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        pay_ready;

  assign desc_ready  = (state_q == ST_IDLE) && !rst_i;
  assign desc_fire   = bus.desc_valid_i && desc_ready;
  assign len_too_big = bus.desc_len_i > MAX_LEN;
  assign pay_fire    = (state_q == ST_PAYLOAD) && bus.pay_valid_i && bus.tx_ready_i;

  // Next-state selection and the byte presented to the transmitter
  always_comb begin
    state_d   = state_q;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    pay_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (desc_fire && !len_too_big) state_d = ST_HDR_OP;
      end
      ST_HDR_OP: begin
        tx_data  = desc_q.opcode;
        tx_valid = 1'b1;
        if (bus.tx_ready_i) state_d = ST_HDR_RSV;
      end
      ST_HDR_RSV: begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        if (bus.tx_ready_i) state_d = ST_HDR_LLSB;
      end
      ST_HDR_LLSB: begin
        tx_data  = total_q[7:0];
        tx_valid = 1'b1;
        if (bus.tx_ready_i) state_d = ST_HDR_LMSB;
      end
      ST_HDR_LMSB: begin
        tx_data  = total_q[15:8];
        tx_valid = 1'b1;
        if (bus.tx_ready_i) state_d = (desc_q.len != 16'd0) ? ST_PAYLOAD : ST_DONE;
      end
      ST_PAYLOAD: begin
        tx_data   = bus.pay_data_i;
        tx_valid  = bus.pay_valid_i;
        pay_ready = bus.tx_ready_i;
        if (pay_fire && (remaining_q == 16'd1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured descriptor, remaining-byte counter and length-error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      desc_q      <= '0;
      total_q     <= 16'd0;
      remaining_q <= 16'd0;
      len_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_err_q <= desc_fire && len_too_big;
      if (desc_fire && !len_too_big) begin
        desc_q.opcode <= bus.desc_opcode_i;
        desc_q.len    <= bus.desc_len_i;
        total_q       <= bus.desc_len_i + HDR_LEN;
        remaining_q   <= bus.desc_len_i;
      end else if (pay_fire) begin
        remaining_q <= remaining_q - 16'd1;
      end
    end
  end

  assign bus.desc_ready_o = desc_ready;
  assign bus.pay_ready_o  = pay_ready;
  assign bus.tx_data_o    = tx_data;
  assign bus.tx_valid_o   = tx_valid;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.len_err_o    = len_err_q;

endmodule

// File: tb/tb_uart_alu_resp_framer.sv
// Directed bench for the response framer: header framing, backpressure,
// zero-length and oversize descriptors, payload stalls and mid-packet reset.
module tb_uart_alu_resp_framer;
  import uart_alu_resp_framer_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;

  uart_alu_resp_framer_if bus ();

  uart_alu_resp_framer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running 100 MHz clock
  always #5 clk_i = ~clk_i;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  payload [256];
  logic [7:0]  got [$];
  int          got_cyc [$];
  int          done_cyc;
  bit          saw_pay_ready;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one descriptor and drives payload/tx_ready cycle by cycle,
  // recording every byte accepted by the transmitter.
  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] len,
                               input bit toggle_ready, input int stall_at,
                               input int abort_at);
    int   pay_idx;
    int   stall_left;
    bit   stall_now;
    bit   busy_seen;
    bit   prev_hold;
    bit   aborted;
    logic [7:0] prev_data;
    got.delete();
    got_cyc.delete();
    done_cyc      = -1;
    saw_pay_ready = 1'b0;
    pay_idx       = 0;
    stall_left    = (stall_at >= 0) ? 5 : 0;
    busy_seen     = 1'b0;
    prev_hold     = 1'b0;
    aborted       = 1'b0;
    prev_data     = 8'h00;
    @(posedge clk_i); #1;
    bus.desc_valid_i  = 1'b1;
    bus.desc_opcode_i = op;
    bus.desc_len_i    = len;
    bus.tx_ready_i    = 1'b1;
    @(negedge clk_i);
    checkOutput("desc_ready_offer", bus.desc_ready_o, 1'b1);
    for (int cyc = 1; cyc < 1000; cyc++) begin
      @(posedge clk_i); #1;
      bus.desc_valid_i = 1'b0;
      bus.tx_ready_i   = toggle_ready ? (cyc % 2 == 1) : 1'b1;
      stall_now = (stall_at >= 0) && (pay_idx == stall_at) && (stall_left > 0);
      if (stall_now) begin
        stall_left--;
        bus.pay_valid_i = 1'b0;
        bus.pay_data_i  = 8'h00;
      end else begin
        bus.pay_valid_i = (pay_idx < int'(len));
        bus.pay_data_i  = (pay_idx < int'(len)) ? payload[pay_idx] : 8'h00;
      end
      @(negedge clk_i);
      if (stall_now) checkOutput("stall_tx_valid", bus.tx_valid_o, 1'b0);
      if (prev_hold) begin
        checkOutput("hold_valid", bus.tx_valid_o, 1'b1);
        checkOutput("hold_data", bus.tx_data_o, prev_data);
      end
      prev_hold = bus.tx_valid_o && !bus.tx_ready_i;
      prev_data = bus.tx_data_o;
      if (bus.pay_ready_o) saw_pay_ready = 1'b1;
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        got.push_back(bus.tx_data_o);
        got_cyc.push_back(cyc);
      end
      if (bus.pay_valid_i && bus.pay_ready_o) pay_idx++;
      if (abort_at >= 0 && pay_idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (bus.busy_o) busy_seen = 1'b1;
      else if (busy_seen) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0 && !aborted) begin
      checks++;
      errors++;
      $display("[TB] FAIL packet_timeout observed=no end of packet expected=busy_o low within 1000 cycles");
    end
  endtask

  // Compares the captured stream against header + payload
  task automatic checkPacket(input string tag, input logic [7:0] op,
                             input logic [15:0] len, input int expect_count);
    logic [15:0] total;
    logic [7:0]  hdr [4];
    logic [7:0]  exp_byte;
    total  = len + 16'd4;
    hdr[0] = op;
    hdr[1] = 8'h00;
    hdr[2] = total[7:0];
    hdr[3] = total[15:8];
    checkOutput({tag, "_count"}, got.size(), expect_count);
    for (int i = 0; i < got.size() && i < expect_count; i++) begin
      exp_byte = (i < 4) ? hdr[i] : payload[i-4];
      checkOutput($sformatf("%s_byte%0d", tag, i), got[i], exp_byte);
    end
  endtask

  // Global safety net in case a wait never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=simulation still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i             = 1'b1;
    bus.desc_valid_i  = 1'b0;
    bus.desc_opcode_i = 8'h00;
    bus.desc_len_i    = 16'd0;
    bus.pay_data_i    = 8'h00;
    bus.pay_valid_i   = 1'b0;
    bus.tx_ready_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_desc_ready", bus.desc_ready_o, 1'b0);
    checkOutput("rst_busy", bus.busy_o, 1'b0);
    checkOutput("rst_tx_valid", bus.tx_valid_o, 1'b0);
    checkOutput("rst_tx_data", bus.tx_data_o, 8'h00);
    checkOutput("rst_pay_ready", bus.pay_ready_o, 1'b0);
    checkOutput("rst_len_err", bus.len_err_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_desc_ready", bus.desc_ready_o, 1'b1);

    $display("[TB] echo 4 bytes, tx_ready high");
    payload[0] = 8'h42; payload[1] = 8'h69; payload[2] = 8'h42; payload[3] = 8'h69;
    applyStimulus(OP_ECHO, 16'd4, 1'b0, -1, -1);
    checkPacket("echo", OP_ECHO, 16'd4, 8);
    if (got.size() == 8) begin
      checkOutput("echo_first_cycle", got_cyc[0], 1);
      checkOutput("echo_span", got_cyc[7] - got_cyc[0], 7);
      checkOutput("echo_busy_low_delay", done_cyc - got_cyc[7], 2);
    end

    $display("[TB] mul 4 bytes, tx_ready toggling");
    payload[0] = 8'h00; payload[1] = 8'h01; payload[2] = 8'hE2; payload[3] = 8'h40;
    applyStimulus(OP_MUL32, 16'd4, 1'b1, -1, -1);
    checkPacket("mul", OP_MUL32, 16'd4, 8);

    $display("[TB] zero-length div");
    applyStimulus(OP_DIV32, 16'd0, 1'b0, -1, -1);
    checkPacket("zero", OP_DIV32, 16'd0, 4);
    checkOutput("zero_no_pay_ready", saw_pay_ready, 1'b0);

    $display("[TB] oversize descriptor");
    @(posedge clk_i); #1;
    bus.desc_valid_i  = 1'b1;
    bus.desc_opcode_i = OP_ADD32;
    bus.desc_len_i    = 16'd253;
    bus.tx_ready_i    = 1'b1;
    bus.pay_valid_i   = 1'b1;
    @(negedge clk_i);
    checkOutput("over_desc_ready", bus.desc_ready_o, 1'b1);
    @(posedge clk_i); #1;
    bus.desc_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("over_len_err", bus.len_err_o, 1'b1);
    checkOutput("over_tx_valid", bus.tx_valid_o, 1'b0);
    checkOutput("over_busy", bus.busy_o, 1'b0);
    checkOutput("over_desc_ready_after", bus.desc_ready_o, 1'b1);
    checkOutput("over_pay_ready", bus.pay_ready_o, 1'b0);
    @(posedge clk_i); #1;
    bus.pay_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("over_len_err_single", bus.len_err_o, 1'b0);
    checkOutput("over_tx_valid_later", bus.tx_valid_o, 1'b0);

    $display("[TB] max payload 252 bytes");
    for (int i = 0; i < 252; i++) payload[i] = 8'(i) ^ 8'h5A;
    applyStimulus(OP_ADD32, 16'd252, 1'b0, -1, -1);
    checkPacket("max", OP_ADD32, 16'd252, 256);
    if (got.size() == 256) checkOutput("max_span", got_cyc[255] - got_cyc[0], 255);

    $display("[TB] payload stall of 5 cycles");
    payload[0] = 8'h10; payload[1] = 8'h20; payload[2] = 8'h30; payload[3] = 8'h40;
    payload[4] = 8'h50; payload[5] = 8'h60;
    applyStimulus(OP_ECHO, 16'd6, 1'b0, 2, -1);
    checkPacket("stall", OP_ECHO, 16'd6, 10);

    $display("[TB] reset after 2 of 4 payload bytes");
    payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC; payload[3] = 8'hDD;
    applyStimulus(OP_ECHO, 16'd4, 1'b0, -1, 2);
    checkPacket("abort", OP_ECHO, 16'd4, 6);
    @(posedge clk_i); #1;
    rst_i           = 1'b1;
    bus.pay_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("abort_busy", bus.busy_o, 1'b0);
    checkOutput("abort_tx_valid", bus.tx_valid_o, 1'b0);
    checkOutput("abort_desc_ready_in_rst", bus.desc_ready_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_desc_ready_after", bus.desc_ready_o, 1'b1);
    checkOutput("abort_len_err", bus.len_err_o, 1'b0);

    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
    applyStimulus(OP_ECHO, 16'd4, 1'b0, -1, -1);
    checkPacket("after_rst", OP_ECHO, 16'd4, 8);
    if (got.size() == 8) checkOutput("after_rst_first_cycle", got_cyc[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
